arbitro_reg3: RTL and testbench
===============================

# arbitro_reg3

Two-requester round-robin arbiter and load sequencer for the shared 3-bit enabled operation register of the ULA datapath. Each requester presents a 3-bit value with a req/ack handshake. The block grants one requester, drives the register's data and enable for exactly one load cycle, then holds the loaded value for a fixed number of cycles before accepting another grant. It sits between the control sources (panel input, microsequencer) and the register's D/en pins.

## Interface
- WIDTH, 3: data width of the shared register.
- HOLD, 4: cycles the loaded value is protected after the load cycle; legal range 1..15.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low; shared with the operation register.
- req0  in  1  requester 0 request; held high with d0 stable until ack0.
- d0  in  WIDTH  requester 0 data.
- req1  in  1  requester 1 request; held high with d1 stable until ack1.
- d1  in  WIDTH  requester 1 data.
- ack0  out  1  one-cycle grant/load pulse to requester 0.
- ack1  out  1  one-cycle grant/load pulse to requester 1.
- reg_d  out  WIDTH  to register D.
- reg_en  out  1  to register en; high only in LOAD.
- owner  out  1  ID of the last granted requester.
- busy  out  1  high when the state is not IDLE.

## Operation
- All outputs are registered. Reset values: state IDLE, reg_d=0, reg_en=0, ack0=ack1=0, owner=0, busy=0, hold counter=0, priority pointer favours requester 0.
- FSM states:
  - IDLE: when any req is high at a clock edge, select the winner, latch its data into reg_d, set owner, and go to LOAD. With no request, stay in IDLE.
  - LOAD: lasts exactly one cycle. reg_en=1, and ack of the winner=1. Load counter with HOLD-1, then go to HOLD.
  - HOLD: reg_en=0, acks=0. Decrement the counter each cycle. When the counter is 0, go to IDLE. HOLD lasts exactly HOLD cycles.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester that is not `owner` wins.
  - After reset, with both high, requester 0 wins.
- Requests arriving in LOAD or HOLD are neither acked nor dropped. They are evaluated on the first IDLE edge.
- A requester that keeps req high past the cycle after its ack is treated as a new request.
- reg_d keeps the last loaded value outside LOAD. reg_d is never undefined.
- Counter width is 4 bits, sufficient for HOLD ≤ 15.

## Timing
- Edge k: req sampled high in IDLE.
- Cycle after edge k: ack and reg_en high. Request-to-ack latency is 1 cycle.
- Edge k+1: register Q takes the value.
- Edges k+2 .. k+1+HOLD: HOLD state.
- Earliest next grant edge: k+2+HOLD. With HOLD=4, one load every 6 cycles under continuous contention.
- Reset asserted in any state: next edge forces IDLE with all outputs at their reset values. A pending ack is not issued. The register clears to 0 via the shared rst.
- A LOAD cycle interrupted by reset does not count as a load. The requester must re-request.

## Structure
- Shared package holds:
  - state encoding localparams: ST_IDLE=2'b00, ST_LOAD=2'b01, ST_HOLD=2'b10;
  - requester IDs REQ0=1'b0, REQ1=1'b1;
  - default width constant 3.
- Sub-module `arb_rr2` (combinational): takes req0, req1 and owner; outputs grant_valid and grant_id.
- The FSM, counter and output registers live in arbitro_reg3.
- The integration top instantiates arbitro_reg3 driving the 3-bit enabled register.

## Test plan
- Reset, then req0=1 with d0=3'b101 → ack0 and reg_en high in the next cycle with reg_d=101. The register reads 101 one edge later. busy is high for 1+HOLD=5 cycles.
- After reset, req0 and req1 raised together (d0=001, d1=110) → first grant goes to 0 (reg_d=001). After 5 cycles requester 1 gets ack1 (reg_d=110). Requester 0 never starves under continuous requests, and grants alternate.
- req1 raised during HOLD → no ack1 during HOLD. ack1 is asserted on the cycle after the first IDLE edge.
- rst pulled low during LOAD → next cycle: ack=0, reg_en=0, reg_d=000, busy=0, and the register reads 000. A re-request is then served normally.
- With HOLD=1, back-to-back requests from requester 0 alone → one ack every 3 cycles. reg_en is never high on two consecutive cycles.
- Idle with no requests for 20 cycles → reg_en and both acks remain 0, and reg_d keeps the last loaded value.

Source files
------------

// File: rtl/arbitro_reg3_pkg.sv
// arbitro_reg3 shared definitions
// State encoding, requester IDs and defaults
package arbitro_reg3_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int CNT_W     = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_HOLD = ST_HOLD
    } state_t;

endpackage

// File: rtl/arbitro_reg3_arb_rr2.sv
// arb_rr2: two-way round-robin grant
// Ties go to whoever did not win last
module arb_rr2
    import arbitro_reg3_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic owner,
    output logic grant_valid,
    output logic grant_id
);

    // pick a single winner from the two requests
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = REQ0;
        if (req0 && req1) begin
            grant_id = ~owner;
        end else if (req1) begin
            grant_id = REQ1;
        end
    end

endmodule

// File: rtl/arbitro_reg3.sv
// arbitro_reg3: arbiter and load sequencer
// Grants, pulses one load cycle, then holds
module arbitro_reg3
    import arbitro_reg3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_en,
    output logic             owner,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] d_n;
    logic             ack0_n, ack1_n, en_n;
    logic             owner_n, busy_n;
    logic             last, last_n;
    logic             grant_valid, grant_id;

    // last winner starts as requester 1 so a reset tie favours 0
    arb_rr2 u_arb (
        .req0        (req0),
        .req1        (req1),
        .owner       (last),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // next state and next registered outputs
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = reg_d;
        owner_n = owner;
        last_n  = last;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        en_n    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    state_n = S_LOAD;
                    d_n     = grant_id ? d1 : d0;
                    owner_n = grant_id;
                    last_n  = grant_id;
                    ack0_n  = ~grant_id;
                    ack1_n  = grant_id;
                    en_n    = 1'b1;
                end
            end
            S_LOAD: begin
                state_n = S_HOLD;
                cnt_n   = HOLD_M1;
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // state, counter and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            reg_d  <= '0;
            reg_en <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            owner  <= REQ0;
            last   <= REQ1;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            reg_d  <= d_n;
            reg_en <= en_n;
            ack0   <= ack0_n;
            ack1   <= ack1_n;
            owner  <= owner_n;
            last   <= last_n;
            busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_arbitro_reg3.sv
// tb_arbitro_reg3: directed plus random checks
// Two instances: HOLD=4 and HOLD=1
module tb_arbitro_reg3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] r0, r1;
    logic [2:0] dd0 [2];
    logic [2:0] dd1 [2];
    logic [1:0] o_a0, o_a1, o_en, o_own, o_busy;
    logic [2:0] o_d0, o_d1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rnd   = 0;

    int       nxt  [2];
    int       bend [2];
    bit       tie  [2];
    bit       ea0  [2];
    bit       ea1  [2];
    bit       een  [2];
    bit       eown [2];
    logic [2:0] ed [2];
    bit       prev_en1;

    always #5 clk = ~clk;

    arbitro_reg3 #(.WIDTH(3), .HOLD(4)) u0 (
        .clk(clk), .rst(rst),
        .req0(r0[0]), .d0(dd0[0]),
        .req1(r1[0]), .d1(dd1[0]),
        .ack0(o_a0[0]), .ack1(o_a1[0]),
        .reg_d(o_d0), .reg_en(o_en[0]),
        .owner(o_own[0]), .busy(o_busy[0])
    );

    arbitro_reg3 #(.WIDTH(3), .HOLD(1)) u1 (
        .clk(clk), .rst(rst),
        .req0(r0[1]), .d0(dd0[1]),
        .req1(r1[1]), .d1(dd1[1]),
        .ack0(o_a0[1]), .ack1(o_a1[1]),
        .reg_d(o_d1), .reg_en(o_en[1]),
        .owner(o_own[1]), .busy(o_busy[1])
    );

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: grant allowed once HOLD+2 edges have passed
    task automatic model(input int i);
        int  h;
        bit  w;
        h = (i == 0) ? 4 : 1;
        if (!rst) begin
            ea0[i] = 0; ea1[i] = 0; een[i] = 0;
            eown[i] = 0; tie[i] = 0; ed[i] = 3'd0;
            nxt[i] = cyc + 1; bend[i] = cyc - 1;
        end else begin
            ea0[i] = 0; ea1[i] = 0; een[i] = 0;
            if (cyc >= nxt[i] && (r0[i] || r1[i])) begin
                if (r0[i] && r1[i]) w = tie[i];
                else w = r1[i];
                ea0[i] = !w; ea1[i] = w; een[i] = 1;
                eown[i] = w; tie[i] = !w;
                ed[i] = w ? dd1[i] : dd0[i];
                nxt[i] = cyc + h + 2;
                bend[i] = cyc + h;
            end
        end
    endtask

    task automatic drive0();
        if (r0[0]) begin
            if (ea0[0]) begin
                r0[0] = 1'($urandom_range(0, 1));
                dd0[0] = 3'($urandom);
            end
        end else if ($urandom_range(0, 2) == 0) begin
            r0[0] = 1'b1; dd0[0] = 3'($urandom);
        end
        if (r1[0]) begin
            if (ea1[0]) begin
                r1[0] = 1'($urandom_range(0, 1));
                dd1[0] = 3'($urandom);
            end
        end else if ($urandom_range(0, 2) == 0) begin
            r1[0] = 1'b1; dd1[0] = 3'($urandom);
        end
    endtask

    task automatic tick();
        logic [2:0] od;
        @(posedge clk);
        cyc++;
        model(0);
        model(1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            od = (i == 0) ? o_d0 : o_d1;
            chk($sformatf("u%0d.ack0", i), {3'b0, o_a0[i]}, {3'b0, ea0[i]});
            chk($sformatf("u%0d.ack1", i), {3'b0, o_a1[i]}, {3'b0, ea1[i]});
            chk($sformatf("u%0d.reg_en", i), {3'b0, o_en[i]}, {3'b0, een[i]});
            chk($sformatf("u%0d.reg_d", i), {1'b0, od}, {1'b0, ed[i]});
            chk($sformatf("u%0d.owner", i), {3'b0, o_own[i]}, {3'b0, eown[i]});
            chk($sformatf("u%0d.busy", i), {3'b0, o_busy[i]},
                {3'b0, (cyc <= bend[i])});
        end
        chk("u1.en_twice", {3'b0, prev_en1 & o_en[1]}, 4'd0);
        prev_en1 = o_en[1];
        if (rst && ea0[1]) dd0[1] = 3'($urandom);
        if (rnd) drive0();
    endtask

    task automatic wait_ack(input bit which, input int lim, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(which ? o_a1[0] : o_a0[0]) && n < lim);
    endtask

    initial begin
        int n, bc;
        prev_en1 = 0;
        rst = 1'b0;
        r0 = 2'b00; r1 = 2'b00;
        dd0[0] = 0; dd0[1] = 0; dd1[0] = 0; dd1[1] = 0;
        tick();
        tick();
        chk("rst.busy", {3'b0, o_busy[0]}, 4'd0);
        chk("rst.reg_d", {1'b0, o_d0}, 4'd0);
        rst = 1'b1;

        r0[0] = 1'b1; dd0[0] = 3'b101;
        r0[1] = 1'b1; dd0[1] = 3'b011;
        tick();
        chk("a.ack0", {3'b0, o_a0[0]}, 4'd1);
        chk("a.reg_d", {1'b0, o_d0}, 4'b0101);
        r0[0] = 1'b0;
        bc = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            bc += int'(o_busy[0]);
        end
        chk("a.busy_len", 4'(bc), 4'd5);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        r0[0] = 1'b1; r1[0] = 1'b1;
        dd0[0] = 3'b001; dd1[0] = 3'b110;
        tick();
        chk("b.first0", {3'b0, o_a0[0]}, 4'd1);
        chk("b.d001", {1'b0, o_d0}, 4'b0001);
        wait_ack(1'b1, 12, n);
        chk("b.gap1", 4'(n), 4'd6);
        chk("b.d110", {1'b0, o_d0}, 4'b0110);
        wait_ack(1'b0, 12, n);
        chk("b.gap0", 4'(n), 4'd6);
        r0[0] = 1'b0; r1[0] = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        r0[0] = 1'b1; dd0[0] = 3'b010;
        tick();
        r0[0] = 1'b0;
        tick();
        r1[0] = 1'b1; dd1[0] = 3'b111;
        wait_ack(1'b1, 12, n);
        chk("c.wait", 4'(n), 4'd5);
        r1[0] = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        r0[0] = 1'b1; dd0[0] = 3'b110;
        tick();
        rst = 1'b0;
        tick();
        chk("d.ack0", {3'b0, o_a0[0]}, 4'd0);
        chk("d.en", {3'b0, o_en[0]}, 4'd0);
        chk("d.reg_d", {1'b0, o_d0}, 4'd0);
        chk("d.busy", {3'b0, o_busy[0]}, 4'd0);
        rst = 1'b1;
        tick();
        chk("d.reack", {3'b0, o_a0[0]}, 4'd1);
        chk("d.red", {1'b0, o_d0}, 4'b0110);
        r0[0] = 1'b0;

        for (int k = 0; k < 26; k++) tick();
        chk("e.keep", {1'b0, o_d0}, 4'b0110);

        rnd = 1;
        for (int k = 0; k < 400; k++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
